fxp_alu_arbiter: RTL and testbench
==================================

FXP_ALU_ARBITER -- requirements
Module: fxp_alu_arbiter

Interface
REQ-001 The block SHALL have parameter INT_WIDTH, default 4, meaning integer bits of the signed fixed-point format.
REQ-002 The block SHALL have parameter FRAC_WIDTH, default 4, meaning fraction bits; DW = INT_WIDTH+FRAC_WIDTH+1 is derived and not overridable.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, rising-edge clock) and rst_n (input, 1, async active-low reset).
REQ-004 The block SHALL have req_valid, input, 2 bits: per-requester request valid, bit i = requester i.
REQ-005 The block SHALL have req_ready, output, 2 bits: per-requester grant/accept, at most one bit high.
REQ-006 The block SHALL have req_a and req_b, inputs, 2*DW bits each: signed operands, requester i in slice [i*DW +: DW].
REQ-007 The block SHALL have req_op, input, 4 bits: 2-bit opcode per requester, 00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-008 The block SHALL have rsp_valid (output, 1), rsp_ready (input, 1), rsp_result (output, DW, signed), rsp_id (output, 1, source requester), rsp_overflow (output, 1) and rsp_div_zero (output, 1).
REQ-009 The block SHALL have busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-010 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-011 In IDLE, req_ready SHALL be the one-hot round-robin grant among asserted req_valid bits; in EXEC and RESP, req_ready SHALL be 0.
REQ-012 Round-robin SHALL give priority to the requester not granted last; after reset, requester 0 has priority.
REQ-013 A request SHALL be accepted on req_valid[i]&req_ready[i]: operands, op and id are latched, the pointer is updated and the FSM goes to EXEC.
REQ-014 ADD and SUB SHALL compute a+b and a-b in one EXEC cycle.
REQ-015 MUL SHALL compute the full 2*DW signed product arithmetically shifted right by FRAC_WIDTH (truncation toward -inf), in one EXEC cycle.
REQ-016 DIV with b!=0 SHALL compute (a<<<FRAC_WIDTH)/b truncated toward zero, using an iterative restoring divider on magnitudes with a sign fixup, taking exactly DW+FRAC_WIDTH EXEC cycles via a down-counter.
REQ-017 DIV with b==0 SHALL take one EXEC cycle and produce result 0, rsp_div_zero=1 and rsp_overflow=0.
REQ-018 rsp_overflow SHALL be 1 when the exact result (after the shift for MUL, the quotient for DIV) lies outside [-2^(DW-1), 2^(DW-1)-1].
REQ-019 On the last EXEC cycle the result SHALL be registered and the FSM SHALL enter RESP; rsp_valid SHALL be 1 only in RESP.
REQ-020 rsp_result, rsp_id and the flags SHALL be held stable while rsp_valid=1 and rsp_ready=0.
REQ-021 On rsp_valid&rsp_ready the FSM SHALL return to IDLE; no new request is accepted in that same cycle.
REQ-022 Latency from the accept edge to rsp_valid high SHALL be 2 cycles for ADD/SUB/MUL/DIV-by-zero and DW+FRAC_WIDTH+1 cycles for DIV.
REQ-023 Requester inputs SHALL be ignored after acceptance; changes to them SHALL not affect the in-flight result.

Reset
REQ-024 On rst_n low, asynchronously: FSM=IDLE, round-robin pointer to requester-0 priority, divider counter=0, rsp_valid=0, rsp_result=0, rsp_id=0, rsp_overflow=0, rsp_div_zero=0, busy=0.
REQ-025 Reset asserted mid-EXEC or mid-RESP SHALL abort the operation with no response issued.

Configuration
REQ-026 With macro FXP_ARB_SATURATE_EN defined, an overflowing rsp_result SHALL clamp to 2^(DW-1)-1 or -2^(DW-1) by the sign of the exact result.
REQ-027 Without FXP_ARB_SATURATE_EN, rsp_result SHALL be the low DW bits of the exact result (wrap); rsp_overflow behaves identically in both builds.

Verification
REQ-028 The bench SHALL cover: req0 MUL a=32, b=32, rsp_ready=1 -> rsp_result=64, overflow=0, id=0, rsp_valid 2 cycles after accept.
REQ-029 The bench SHALL cover: req1 DIV a=16, b=-8 -> rsp_result=-32, id=1, rsp_valid exactly 14 cycles after accept.
REQ-030 The bench SHALL cover: both req_valid high continuously after reset -> grants 0,1,0,1 in order, never both ready.
REQ-031 The bench SHALL cover: ADD a=255, b=1 -> overflow=1, result=-256 (wrap) or 255 (FXP_ARB_SATURATE_EN).
REQ-032 The bench SHALL cover: DIV a=40, b=0 -> result=0, div_zero=1, and rsp_ready held low 5 cycles -> outputs stable, busy=1.
REQ-033 The bench SHALL cover: rst_n pulsed low during a DIV EXEC -> all outputs 0 immediately, no response, next accept granted to requester 0.

Source files
------------

// File: rtl/fxp_alu_arbiter.sv
`default_nettype none
// ==========================================================================
// fxp_alu_arbiter : 2-requester round-robin front end to a signed fixed-point ALU
// Rev 1.0 | define FXP_ARB_SATURATE_EN to clamp overflowing results
// ==========================================================================
module fxp_alu_arbiter #(
  parameter  int INT_WIDTH  = 4,
  parameter  int FRAC_WIDTH = 4,
  localparam int DW         = INT_WIDTH + FRAC_WIDTH + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*DW-1:0]      req_a,
  input  logic [2*DW-1:0]      req_b,
  input  logic [3:0]           req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic signed [DW-1:0] rsp_result,
  output logic                 rsp_id,
  output logic                 rsp_overflow,
  output logic                 rsp_div_zero,
  output logic                 busy
);

  localparam int QW = DW + FRAC_WIDTH;  // dividend / quotient magnitude width
  localparam int EW = 2 * DW;           // wide enough to hold any exact result
  localparam int CW = $clog2(QW + 1);

  localparam logic [CW-1:0]        C_DIV_STEPS = CW'(QW);
  localparam logic signed [EW-1:0] C_MAX = {{(EW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [EW-1:0] C_MIN = {{(EW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 prio_q;
  logic                 id_q;
  logic [1:0]           op_q;
  logic signed [DW-1:0] a_q, b_q;
  logic [QW-1:0]        quo_q;
  logic [DW-1:0]        rem_q, bmag_q;
  logic [CW-1:0]        cnt_q;
  logic signed [DW-1:0] res_q;
  logic                 ovf_q, dz_q;

  function automatic logic [DW-1:0] f_mag(input logic [DW-1:0] v);
    return v[DW-1] ? (~v + DW'(1)) : v;
  endfunction

  // Round-robin grant: the priority holder wins, otherwise the other requester
  logic [1:0] w_gnt;
  logic       w_other;
  logic       w_accept;
  logic       w_sel;

  assign w_other = ~prio_q;

  always_comb begin
    w_gnt = 2'b00;
    if (req_valid[prio_q])
      w_gnt[prio_q] = 1'b1;
    else if (req_valid[w_other])
      w_gnt[w_other] = 1'b1;
  end

  assign w_accept = (state_q == S_IDLE) && (w_gnt != 2'b00);
  assign w_sel    = w_gnt[1];

  logic signed [DW-1:0] w_sel_a, w_sel_b;
  assign w_sel_a = w_sel ? req_a[2*DW-1:DW] : req_a[DW-1:0];
  assign w_sel_b = w_sel ? req_b[2*DW-1:DW] : req_b[DW-1:0];

  // One restoring-division step on magnitudes; remainder always stays below |b|
  logic [DW:0]   w_rem_sh;
  logic          w_ge;
  logic [DW-1:0] w_rem_nx;
  logic [QW-1:0] w_quo_nx;

  assign w_rem_sh = {rem_q, quo_q[QW-1]};
  assign w_ge     = w_rem_sh >= {1'b0, bmag_q};
  assign w_rem_nx = w_ge ? DW'(w_rem_sh - {1'b0, bmag_q}) : w_rem_sh[DW-1:0];
  assign w_quo_nx = {quo_q[QW-2:0], w_ge};

  logic signed [EW-1:0] w_a_x, w_b_x, w_prod, w_q_x, w_exact;
  assign w_a_x  = {{(EW-DW){a_q[DW-1]}}, a_q};
  assign w_b_x  = {{(EW-DW){b_q[DW-1]}}, b_q};
  assign w_prod = w_a_x * w_b_x;
  assign w_q_x  = {{(EW-QW){1'b0}}, w_quo_nx};

  always_comb begin
    case (op_q)
      OP_ADD:  w_exact = w_a_x + w_b_x;
      OP_SUB:  w_exact = w_a_x - w_b_x;
      OP_MUL:  w_exact = w_prod >>> FRAC_WIDTH;
      default: w_exact = (a_q[DW-1] ^ b_q[DW-1]) ? -w_q_x : w_q_x;
    endcase
  end

  logic                 w_ovf;
  logic signed [DW-1:0] w_res;
  logic                 w_bzero, w_dz, w_done;

  assign w_ovf = (w_exact > C_MAX) || (w_exact < C_MIN);

`ifdef FXP_ARB_SATURATE_EN
  assign w_res = !w_ovf ? w_exact[DW-1:0]
               : (w_exact[EW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}});
`else
  assign w_res = w_exact[DW-1:0];
`endif

  assign w_bzero = (b_q == '0);
  assign w_dz    = (op_q == OP_DIV) && w_bzero;
  assign w_done  = (op_q != OP_DIV) || w_bzero || (cnt_q == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_accept)  state_d = S_EXEC;
      S_EXEC:  if (w_done)    state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:  req_ready = w_gnt;
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
      id_q   <= 1'b0;
      op_q   <= OP_ADD;
      a_q    <= '0;
      b_q    <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      bmag_q <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
      ovf_q  <= 1'b0;
      dz_q   <= 1'b0;
    end else if (w_accept) begin
      prio_q <= ~w_sel;
      id_q   <= w_sel;
      op_q   <= w_sel ? req_op[3:2] : req_op[1:0];
      a_q    <= w_sel_a;
      b_q    <= w_sel_b;
      quo_q  <= {f_mag(w_sel_a), {FRAC_WIDTH{1'b0}}};
      rem_q  <= '0;
      bmag_q <= f_mag(w_sel_b);
      cnt_q  <= C_DIV_STEPS;
    end else if (state_q == S_EXEC) begin
      if ((op_q == OP_DIV) && !w_bzero) begin
        quo_q <= w_quo_nx;
        rem_q <= w_rem_nx;
        cnt_q <= cnt_q - CW'(1);
      end
      if (w_done) begin
        res_q <= w_dz ? '0 : w_res;
        ovf_q <= !w_dz && w_ovf;
        dz_q  <= w_dz;
      end
    end
  end

  assign rsp_result   = res_q;
  assign rsp_id       = id_q;
  assign rsp_overflow = ovf_q;
  assign rsp_div_zero = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_fxp_alu_arbiter.sv
`default_nettype none
// tb_fxp_alu_arbiter : directed + randomized transactions checked against an
// arithmetic reference model of the arbiter and fixed-point ALU.
module tb_fxp_alu_arbiter;

  localparam int DW   = 9;
  localparam int FSC  = 16;    // 2^FRAC_WIDTH
  localparam int VMAX = 255;
  localparam int VMIN = -256;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [2*DW-1:0]      req_a, req_b;
  logic [3:0]           req_op;
  logic                 rsp_valid, rsp_ready;
  logic signed [DW-1:0] rsp_result;
  logic                 rsp_id, rsp_overflow, rsp_div_zero, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_prio = 0;

  always #5 clk = ~clk;

  fxp_alu_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_id       (rsp_id),
    .rsp_overflow (rsp_overflow),
    .rsp_div_zero (rsp_div_zero),
    .busy         (busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: exact arithmetic on integers, then range test and wrap/clamp
  function automatic void model(input int op, input int a, input int b,
                                output int res, output int ovf, output int dz,
                                output int lat);
    int exact, p;
    dz = 0; lat = 2; exact = 0;
    case (op)
      0: exact = a + b;
      1: exact = a - b;
      2: begin
        p = a * b;
        exact = p / FSC;
        if (p < 0 && (p % FSC) != 0) exact = exact - 1;
      end
      default: begin
        if (b == 0) dz = 1;
        else begin
          exact = (a * FSC) / b;
          lat = 13 + 1;
        end
      end
    endcase
    ovf = (exact > VMAX || exact < VMIN) ? 1 : 0;
    res = exact & 511;
    if (res > VMAX) res = res - 512;
`ifdef FXP_ARB_SATURATE_EN
    if (exact > VMAX) res = VMAX;
    else if (exact < VMIN) res = VMIN;
`endif
  endfunction

  task automatic apply_reset();
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    exp_prio = 0;
  endtask

  task automatic do_txn(input logic [1:0] vmask, input logic [1:0] op0, input logic [1:0] op1,
                        input logic signed [DW-1:0] a0, input logic signed [DW-1:0] b0,
                        input logic signed [DW-1:0] a1, input logic signed [DW-1:0] b1,
                        input int hold);
    int gid, e_res, e_ovf, e_dz, e_lat, n;
    @(negedge clk);
    req_valid = vmask;
    req_op    = {op1, op0};
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    rsp_ready = (hold == 0);
    #1;
    gid = vmask[exp_prio] ? exp_prio : 1 - exp_prio;
    check("grant", int'(req_ready), 1 << gid);
    exp_prio = 1 - gid;
    if (gid == 0) model(int'(op0), int'(a0), int'(b0), e_res, e_ovf, e_dz, e_lat);
    else          model(int'(op1), int'(a1), int'(b1), e_res, e_ovf, e_dz, e_lat);
    @(negedge clk);
    req_valid = 2'b00;
    req_a     = (2*DW)'($urandom);
    req_b     = (2*DW)'($urandom);
    req_op    = 4'($urandom);
    n = 1;
    #1;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("latency", n, e_lat);
    if (!rsp_valid) begin
      apply_reset();
      return;
    end
    check("result", int'(rsp_result), e_res);
    check("overflow", int'(rsp_overflow), e_ovf);
    check("div_zero", int'(rsp_div_zero), e_dz);
    check("id", int'(rsp_id), gid);
    check("busy_resp", int'(busy), 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      check("hold_valid", int'(rsp_valid), 1);
      check("hold_result", int'(rsp_result), e_res);
      check("hold_flags", int'({rsp_id, rsp_overflow, rsp_div_zero}), (gid << 2) | (e_ovf << 1) | e_dz);
      check("hold_busy", int'(busy), 1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("valid_dropped", int'(rsp_valid), 0);
    check("idle_after_rsp", int'(busy), 0);
  endtask

  logic signed [DW-1:0] ra0, rb0, ra1, rb1;
  logic [1:0]           rop0, rop1, rvm;
  int                   ng, nrsp;

  initial begin
    req_valid = 2'b00; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    check("rst_valid", int'(rsp_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_result", int'(rsp_result), 0);
    check("rst_flags", int'({rsp_id, rsp_overflow, rsp_div_zero}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // both requesters held valid: strict alternation starting at 0
    @(negedge clk);
    req_valid = 2'b11; req_op = 4'b0000;
    req_a = {9'sd3, 9'sd1}; req_b = {9'sd4, 9'sd2}; rsp_ready = 1'b1;
    ng = 0;
    for (int c = 0; c < 14; c++) begin
      #1;
      if (req_ready != 2'b00) begin
        check("rr_onehot", $countones(req_ready), 1);
        check("rr_order", int'(req_ready[1]), ng % 2);
        ng++;
      end
      if (rsp_valid) check("rr_no_grant_in_resp", int'(req_ready), 0);
      @(negedge clk);
    end
    check("rr_grants", ng, 5);
    apply_reset();

    do_txn(2'b01, 2'b10, 2'b00, 9'sd32, 9'sd32, 9'sd0, 9'sd0, 0);    // MUL 2.0*2.0
    do_txn(2'b10, 2'b00, 2'b11, 9'sd0, 9'sd0, 9'sd16, -9'sd8, 0);    // DIV 1.0/-0.5
    do_txn(2'b01, 2'b11, 2'b00, 9'sd40, 9'sd0, 9'sd0, 9'sd0, 5);     // DIV by zero, held
    do_txn(2'b10, 2'b00, 2'b00, 9'sd0, 9'sd0, 9'sd255, 9'sd1, 0);    // ADD overflow

    // reset pulse in the middle of a divide
    @(negedge clk);
    req_valid = 2'b01; req_op = 4'b0011;
    req_a = {9'sd5, 9'sd100}; req_b = {9'sd5, 9'sd7}; rsp_ready = 1'b1;
    #1;
    check("abort_grant", int'(req_ready), 1);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_valid", int'(rsp_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_result", int'(rsp_result), 0);
    check("abort_flags", int'({rsp_id, rsp_overflow, rsp_div_zero}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_prio = 0;
    nrsp = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (rsp_valid) nrsp++;
    end
    check("abort_no_rsp", nrsp, 0);
    do_txn(2'b11, 2'b00, 2'b00, 9'sd1, 9'sd1, 9'sd2, 9'sd2, 0);      // requester 0 first again

    for (int t = 0; t < 40; t++) begin
      rvm  = 2'($urandom_range(1, 3));
      rop0 = 2'($urandom);
      rop1 = 2'($urandom);
      ra0  = DW'($urandom);
      rb0  = ($urandom_range(0, 5) == 0) ? '0 : DW'($urandom);
      ra1  = DW'($urandom);
      rb1  = ($urandom_range(0, 5) == 0) ? '0 : DW'($urandom);
      do_txn(rvm, rop0, rop1, ra0, rb0, ra1, rb1, int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
